// File: rtl/upgrade_spawn_ctrl_if.sv
// Signal bundle between the question-block spawn controller and the game logic.
// The master drives level and strike requests. The slave returns the spawn position and render state.
interface upgrade_spawn_ctrl_if;
  logic [2:0] level_num;
  logic       mario_hit_req;
  logic       luigi_hit_req;
  logic [1:0] mario_hit_idx;
  logic [1:0] luigi_hit_idx;
  logic       upgrade_done;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic       spawn_valid;
  logic [3:0] q_empty;
  logic [1:0] bump_idx;
  logic [3:0] bump_off;
  logic       busy;
  logic       served_luigi;

  modport master (
    output level_num, mario_hit_req, luigi_hit_req, mario_hit_idx, luigi_hit_idx, upgrade_done,
    input  spawn_x, spawn_y, spawn_valid, q_empty, bump_idx, bump_off, busy, served_luigi
  );

  modport slave (
    input  level_num, mario_hit_req, luigi_hit_req, mario_hit_idx, luigi_hit_idx, upgrade_done,
    output spawn_x, spawn_y, spawn_valid, q_empty, bump_idx, bump_off, busy, served_luigi
  );
endinterface

// File: rtl/upgrade_spawn_ctrl.sv
// Arbitrates head-strikes on the four question blocks, then runs bump, emerge and active phases of one upgrade.
// One frame per edge. Requests are dropped unless the block is idle and on the question level.
module upgrade_spawn_ctrl #(
  parameter logic [2:0] Q_LEVEL = 3'd1,
  parameter logic [9:0] Q_X0 = 10'd110,
  parameter logic [9:0] Q_X1 = 10'd210,
  parameter logic [9:0] Q_X2 = 10'd310,
  parameter logic [9:0] Q_X3 = 10'd410,
  parameter logic [9:0] Q_Y0 = 10'd249,
  parameter logic [9:0] Q_Y1 = 10'd249,
  parameter logic [9:0] Q_Y2 = 10'd249,
  parameter logic [9:0] Q_Y3 = 10'd249
) (
  input logic frame_clk,
  input logic Reset,
  upgrade_spawn_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUMP   = 2'd1;
  localparam logic [1:0] EMERGE = 2'd2;
  localparam logic [1:0] ACTIVE = 2'd3;

  logic [1:0] r_state;
  logic [4:0] r_cnt;
  logic [3:0] r_q_empty;
  logic [1:0] r_bump_idx;
  logic       r_served_luigi;

  logic       w_level_ok;
  logic       w_m_elig;
  logic       w_l_elig;
  logic       w_win_luigi;
  logic       w_grant;
  logic [1:0] w_gidx;
  logic [9:0] w_qx;
  logic [9:0] w_qy;
  logic [3:0] w_bump_off;

  assign w_level_ok  = (bus.level_num == Q_LEVEL);
  assign w_m_elig    = bus.mario_hit_req && !r_q_empty[bus.mario_hit_idx];
  assign w_l_elig    = bus.luigi_hit_req && !r_q_empty[bus.luigi_hit_idx];
  // On a tie the player who was not served last time wins.
  assign w_win_luigi = w_l_elig && (!w_m_elig || !r_served_luigi);
  assign w_grant     = w_m_elig || w_l_elig;
  assign w_gidx      = w_win_luigi ? bus.luigi_hit_idx : bus.mario_hit_idx;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state        <= IDLE;
      r_cnt          <= 5'd0;
      r_q_empty      <= 4'b0000;
      r_bump_idx     <= 2'd0;
      r_served_luigi <= 1'b1;
    end else if (!w_level_ok) begin
      // Leaving the level forfeits any in-flight upgrade. The used flags persist.
      r_state <= IDLE;
      r_cnt   <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_q_empty[w_gidx] <= 1'b1;
            r_bump_idx        <= w_gidx;
            r_served_luigi    <= w_win_luigi;
            r_state           <= BUMP;
            r_cnt             <= 5'd0;
          end
        end
        BUMP: begin
          if (r_cnt == 5'd7) begin
            r_state <= EMERGE;
            r_cnt   <= 5'd0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        EMERGE: begin
          if (r_cnt == 5'd19) begin
            r_state <= ACTIVE;
            r_cnt   <= 5'd0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: begin
          if (bus.upgrade_done) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_qx = Q_X0;
    w_qy = Q_Y0;
    case (r_bump_idx)
      2'd1:    begin w_qx = Q_X1; w_qy = Q_Y1; end
      2'd2:    begin w_qx = Q_X2; w_qy = Q_Y2; end
      2'd3:    begin w_qx = Q_X3; w_qy = Q_Y3; end
      default: begin w_qx = Q_X0; w_qy = Q_Y0; end
    endcase
  end

  // Triangle profile: the block rises 6 px and falls back over eight frames.
  always_comb begin
    w_bump_off = 4'd0;
    case (r_cnt[2:0])
      3'd1, 3'd6: w_bump_off = 4'd2;
      3'd2, 3'd5: w_bump_off = 4'd4;
      3'd3, 3'd4: w_bump_off = 4'd6;
      default:    w_bump_off = 4'd0;
    endcase
  end

  always_comb begin
    bus.spawn_x = 10'd800;
    bus.spawn_y = 10'd0;
    if (r_state == EMERGE) begin
      bus.spawn_x = w_qx;
      bus.spawn_y = w_qy - 10'd1 - {5'd0, r_cnt};
    end else if (r_state == ACTIVE) begin
      bus.spawn_x = w_qx;
      bus.spawn_y = w_qy - 10'd20;
    end
  end

  assign bus.bump_off     = (r_state == BUMP) ? w_bump_off : 4'd0;
  assign bus.spawn_valid  = (r_state == ACTIVE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.q_empty      = r_q_empty;
  assign bus.bump_idx     = r_bump_idx;
  assign bus.served_luigi = r_served_luigi;

endmodule

// File: tb/tb_upgrade_spawn_ctrl.sv
// Bench for upgrade_spawn_ctrl: frame-by-frame vector tables checked through an expected-output queue.
// It also includes hand-written asynchronous reset pulses and level-change aborts.
module tb_upgrade_spawn_ctrl;

  typedef struct packed {
    logic       busy;
    logic       sv;
    logic [9:0] sx;
    logic [9:0] sy;
    logic [3:0] qe;
    logic [1:0] bidx;
    logic [3:0] boff;
    logic       sl;
  } out_t;

  typedef struct {
    string      nm;
    logic [2:0] lvl;
    logic       mr;
    logic [1:0] mi;
    logic       lr;
    logic [1:0] li;
    logic       dn;
    out_t       e;
  } vec_t;

  logic frame_clk;
  logic Reset;
  upgrade_spawn_ctrl_if bus();

  upgrade_spawn_ctrl dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus)
  );

  int    checks = 0;
  int    errors = 0;
  vec_t  tbl[$];
  out_t  sb[$];
  string sb_nm[$];
  logic [3:0] boff_tbl [8];

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic out_t mk(logic b, logic v, logic [9:0] x, logic [9:0] y,
                              logic [3:0] q, logic [1:0] bi, logic [3:0] bo, logic s);
    out_t o;
    o = {b, v, x, y, q, bi, bo, s};
    return o;
  endfunction

  function automatic out_t rst_vals();
    return mk(1'b0, 1'b0, 10'd800, 10'd0, 4'b0000, 2'd0, 4'd0, 1'b1);
  endfunction

  task automatic add(input string nm, input logic [2:0] lvl, input logic mr, input logic [1:0] mi,
                     input logic lr, input logic [1:0] li, input logic dn, input out_t e);
    vec_t v;
    v.nm = nm; v.lvl = lvl; v.mr = mr; v.mi = mi; v.lr = lr; v.li = li; v.dn = dn; v.e = e;
    tbl.push_back(v);
  endtask

  // Rows for the frames that follow a grant row: bump 1..7, n_em emerge frames, and n_act active frames.
  task automatic life(input logic [1:0] idx, input logic [3:0] qe, input logic sl,
                      input logic [9:0] x, input logic [9:0] y, input bit noise,
                      input int n_em, input int n_act);
    logic [9:0] ey;
    for (int k = 1; k < 8; k++)
      add("bump", 3'd1, noise && (k == 2), idx + 2'd1, noise && (k == 4), idx + 2'd2, 1'b0,
          mk(1'b1, 1'b0, 10'd800, 10'd0, qe, idx, boff_tbl[k], sl));
    for (int k = 0; k < n_em; k++) begin
      ey = y - 10'(k + 1);
      add("emerge", 3'd1, noise && (k == 3), idx + 2'd1, 1'b0, 2'd0, noise && (k == 5),
          mk(1'b1, 1'b0, x, ey, qe, idx, 4'd0, sl));
    end
    for (int k = 0; k < n_act; k++)
      add("active", 3'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0,
          mk(1'b1, 1'b1, x, y - 10'd20, qe, idx, 4'd0, sl));
  endtask

  task automatic check_pop();
    out_t got;
    out_t e;
    string nm;
    got = {bus.busy, bus.spawn_valid, bus.spawn_x, bus.spawn_y, bus.q_empty,
           bus.bump_idx, bus.bump_off, bus.served_luigi};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: got output %h with no expected entry", got);
    end else begin
      e  = sb.pop_front();
      nm = sb_nm.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got busy=%b sv=%b x=%0d y=%0d qe=%b bidx=%0d boff=%0d sl=%b, expected busy=%b sv=%b x=%0d y=%0d qe=%b bidx=%0d boff=%0d sl=%b",
                 nm, got.busy, got.sv, got.sx, got.sy, got.qe, got.bidx, got.boff, got.sl,
                 e.busy, e.sv, e.sx, e.sy, e.qe, e.bidx, e.boff, e.sl);
      end
    end
  endtask

  task automatic expect_now(input string nm, input out_t e);
    sb.push_back(e);
    sb_nm.push_back(nm);
    check_pop();
  endtask

  task automatic apply_tbl();
    foreach (tbl[i]) begin
      bus.level_num     = tbl[i].lvl;
      bus.mario_hit_req = tbl[i].mr;
      bus.mario_hit_idx = tbl[i].mi;
      bus.luigi_hit_req = tbl[i].lr;
      bus.luigi_hit_idx = tbl[i].li;
      bus.upgrade_done  = tbl[i].dn;
      sb.push_back(tbl[i].e);
      sb_nm.push_back(tbl[i].nm);
      @(posedge frame_clk);
      #1;
      check_pop();
    end
    tbl.delete();
    bus.mario_hit_req = 1'b0;
    bus.luigi_hit_req = 1'b0;
    bus.upgrade_done  = 1'b0;
  endtask

  initial begin
    boff_tbl = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd6, 4'd4, 4'd2, 4'd0};
    Reset = 1'b1;
    bus.level_num = 3'd1;
    bus.mario_hit_req = 1'b0; bus.mario_hit_idx = 2'd0;
    bus.luigi_hit_req = 1'b0; bus.luigi_hit_idx = 2'd0;
    bus.upgrade_done = 1'b0;
    #12;
    expect_now("reset_state", rst_vals());
    Reset = 1'b0;

    // Single Mario strike on block 2: full bump/emerge/active life, then idle release.
    add("idle",        3'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, rst_vals());
    add("wrong_level", 3'd2, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, rst_vals());
    add("done_idle",   3'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, rst_vals());
    add("grant_m2",    3'd1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0,
        mk(1'b1, 1'b0, 10'd800, 10'd0, 4'b0100, 2'd2, 4'd0, 1'b0));
    life(2'd2, 4'b0100, 1'b0, 10'd310, 10'd249, 1'b1, 20, 1);
    add("active_req",  3'd1, 1'b1, 2'd2, 1'b1, 2'd0, 1'b0,
        mk(1'b1, 1'b1, 10'd310, 10'd229, 4'b0100, 2'd2, 4'd0, 1'b0));
    add("done",        3'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1,
        mk(1'b0, 1'b0, 10'd800, 10'd0, 4'b0100, 2'd2, 4'd0, 1'b0));
    add("used_idx2",   3'd1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0,
        mk(1'b0, 1'b0, 10'd800, 10'd0, 4'b0100, 2'd2, 4'd0, 1'b0));
    apply_tbl();

    #2 Reset = 1'b1;
    #1 expect_now("reset_idle_pulse", rst_vals());
    Reset = 1'b0;

    // Round robin: Mario wins the first tie, then Luigi wins the next tie. Level abort occurs during emerge.
    add("both_01",     3'd1, 1'b1, 2'd0, 1'b1, 2'd1, 1'b0,
        mk(1'b1, 1'b0, 10'd800, 10'd0, 4'b0001, 2'd0, 4'd0, 1'b0));
    life(2'd0, 4'b0001, 1'b0, 10'd110, 10'd249, 1'b0, 20, 1);
    add("done_01",     3'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1,
        mk(1'b0, 1'b0, 10'd800, 10'd0, 4'b0001, 2'd0, 4'd0, 1'b0));
    add("both_23",     3'd1, 1'b1, 2'd2, 1'b1, 2'd3, 1'b0,
        mk(1'b1, 1'b0, 10'd800, 10'd0, 4'b1001, 2'd3, 4'd0, 1'b1));
    life(2'd3, 4'b1001, 1'b1, 10'd410, 10'd249, 1'b0, 4, 0);
    add("lvl2_abort",  3'd2, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0,
        mk(1'b0, 1'b0, 10'd800, 10'd0, 4'b1001, 2'd3, 4'd0, 1'b1));
    add("lvl2_req",    3'd2, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0,
        mk(1'b0, 1'b0, 10'd800, 10'd0, 4'b1001, 2'd3, 4'd0, 1'b1));
    add("lvl1_same",   3'd1, 1'b1, 2'd0, 1'b1, 2'd3, 1'b0,
        mk(1'b0, 1'b0, 10'd800, 10'd0, 4'b1001, 2'd3, 4'd0, 1'b1));
    add("same_idx1",   3'd1, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0,
        mk(1'b1, 1'b0, 10'd800, 10'd0, 4'b1011, 2'd1, 4'd0, 1'b0));
    life(2'd1, 4'b1011, 1'b0, 10'd210, 10'd249, 1'b1, 20, 2);
    apply_tbl();

    // Asynchronous reset between edges while active.
    #2 Reset = 1'b1;
    #1 expect_now("reset_mid_active", rst_vals());
    #1 Reset = 1'b0;
    add("post_reset",  3'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, rst_vals());
    add("regrant_3",   3'd1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0,
        mk(1'b1, 1'b0, 10'd800, 10'd0, 4'b1000, 2'd3, 4'd0, 1'b0));
    add("bump_after",  3'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0,
        mk(1'b1, 1'b0, 10'd800, 10'd0, 4'b1000, 2'd3, 4'd2, 1'b0));
    apply_tbl();

    #2 Reset = 1'b1;
    #1 expect_now("reset_mid_bump", rst_vals());
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/upgrade_spawn_ctrl.md
UPGRADE_SPAWN_CTRL -- requirements
Module: upgrade_spawn_ctrl

Interface
REQ-001 The block SHALL have parameter Q_LEVEL, default 3'd1, meaning the level that holds the four question blocks.
REQ-002 The block SHALL have parameters Q_X0..Q_X3, defaults 10'd110/210/310/410, meaning question-block centre X.
REQ-003 The block SHALL have parameters Q_Y0..Q_Y3, default 10'd249 each, meaning question-block centre Y.
REQ-004 The block SHALL have the port: frame_clk  in  1  clock, one edge per video frame.
REQ-005 The block SHALL have the port: Reset  in  1  reset; Reset is asynchronous, active-high; clock is frame_clk.
REQ-006 The block SHALL have the port: level_num  in  3  current level.
REQ-007 The block SHALL have the ports: mario_hit_req / luigi_hit_req  in  1  head-strike on a question block this frame.
REQ-008 The block SHALL have the ports: mario_hit_idx / luigi_hit_idx  in  2  index of the struck block.
REQ-009 The block SHALL have the port: upgrade_done  in  1  the upgrade slot is free (acquired or fell off-screen).
REQ-010 The block SHALL have the ports: spawn_x, spawn_y  out  10  upgrade start position.
REQ-011 The block SHALL have the port: spawn_valid  out  1  drives the upgrade datapath's is_question_empty.
REQ-012 The block SHALL have the port: q_empty  out  4  per-block used flag, for the renderer.
REQ-013 The block SHALL have the port: bump_idx  out  2  the block currently bumping.
REQ-014 The block SHALL have the port: bump_off  out  4  upward pixel offset of the bumping block.
REQ-015 The block SHALL have the ports: busy  out  1  FSM not IDLE; served_luigi  out  1  last grant went to Luigi.

Function
REQ-016 The FSM SHALL have the states IDLE, BUMP, EMERGE and ACTIVE, and all registers SHALL update on posedge frame_clk.
REQ-017 A request SHALL be eligible only when in IDLE, level_num==Q_LEVEL and q_empty[idx]==0; every other request SHALL be dropped with no state change.
REQ-018 When both requests are eligible in the same frame, the player not named by served_luigi SHALL win, i.e. round-robin; served_luigi SHALL update to the winner.
REQ-019 When both players name the same idx, a single grant SHALL occur.
REQ-020 On grant: q_empty[idx] SHALL be set to 1; idx SHALL be latched into bump_idx; the FSM SHALL go to BUMP; a 5-bit frame counter cnt SHALL be set to 0.
REQ-021 In BUMP, bump_off SHALL follow 0,2,4,6,6,4,2,0 for cnt 0..7; after cnt==7 the FSM SHALL go to EMERGE with cnt=0.
REQ-022 In BUMP, bump_off SHALL be 0 outside BUMP.
REQ-023 In EMERGE, spawn_x SHALL equal Q_Xidx and spawn_y SHALL equal Q_Yidx-1-cnt, decrementing 1 per frame.
REQ-024 After cnt==19 in EMERGE (spawn_y=Q_Yidx-20), the FSM SHALL go to ACTIVE.
REQ-025 In ACTIVE, spawn_valid SHALL be 1 and spawn_x/spawn_y SHALL hold Q_Xidx / Q_Yidx-20, the cell above the block.
REQ-026 spawn_valid SHALL be 1 only in ACTIVE, so that the datapath latches the start position.
REQ-027 In ACTIVE, upgrade_done==1 SHALL return the FSM to IDLE and drop spawn_valid to 0 on the same edge.
REQ-028 upgrade_done SHALL be ignored outside ACTIVE.
REQ-029 While level_num!=Q_LEVEL, any state SHALL abort to IDLE next edge with spawn_valid=0 and bump_off=0; q_empty SHALL be retained, so the in-flight upgrade is forfeited.
REQ-030 Subtraction SHALL be 10-bit unsigned; Q_Y SHALL be >=21 by constraint, so no wrap occurs.
REQ-031 When not in EMERGE or ACTIVE, spawn_x SHALL be 10'd800 and spawn_y SHALL be 0, an off-screen park.
REQ-032 busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-033 On Reset, the block SHALL set state=IDLE, cnt=0, q_empty=4'b0000, bump_idx=0, bump_off=0, spawn_valid=0, spawn_x=800, spawn_y=0, served_luigi=1 (Mario wins the first tie) and busy=0.
REQ-034 A reset asserted mid-BUMP, EMERGE or ACTIVE SHALL restore all of these values immediately, without waiting for a clock edge.
REQ-035 q_empty SHALL survive only level changes, never Reset.

Verification
REQ-036 Verification SHALL cover: level=1, mario_hit_req idx=2 for 1 frame -> q_empty=0100; bump_off 0,2,4,6,6,4,2,0; spawn_y 248..229 over 20 frames; then spawn_valid=1 with (310,229).
REQ-037 Verification SHALL cover: both requests in one frame, idx 0 and 1, after reset -> Mario served, q_empty=0001, served_luigi=0; repeat after done with idx 2/3 -> Luigi served.
REQ-038 Verification SHALL cover: request for idx 2 after REQ-036's sequence, or any request while busy -> no change to q_empty, state or cnt.
REQ-039 Verification SHALL cover: ACTIVE with upgrade_done=1 -> next edge IDLE, spawn_valid=0, spawn_x=800, busy=0.
REQ-040 Verification SHALL cover: level_num changed to 2 during EMERGE -> IDLE next edge with q_empty kept; on return to level 1, the same idx SHALL be ignored.
REQ-041 Verification SHALL cover: Reset pulsed mid-ACTIVE between clock edges -> outputs immediately at their REQ-033 values, q_empty=0000.
